stream_linebuffer: RTL and testbench

//  Streaming successor to the whole-frame line buffer. Accepts one pixel (all channels) per valid/ready beat in raster order.

---
 rtl/linebuffer_pkg.sv | 18 +
 rtl/line_delay.sv | 27 ++
 rtl/stream_linebuffer.sv | 160 ++++++++++++++++
 tb/tb_stream_linebuffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// Shared state encoding, counter-width helpers and window slot indexing for stream_linebuffer.
package linebuffer_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lb_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int win_idx(input int r, input int c, input int ch, input int k, input int nch);
        return (r * k + c) * nch + ch;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One image row of delay: DEPTH-deep shift register of pixels that advances only when en is high.
module line_delay #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) mem_d = {mem_q[DEPTH-2:0], din};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/stream_linebuffer.sv
// Streaming KxK window generator with stride decimation and valid/ready on both sides.
// Define LINEBUF_WEIGHT_LATCH_EN to add the weights/filter ports latched once per frame.
module stream_linebuffer
    import linebuffer_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int POINT_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int STRIDE      = 1
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [POINT_WIDTH*CHANNELS-1:0]                       in_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [POINT_WIDTH*CHANNELS*KERNEL_SIZE*KERNEL_SIZE-1:0] window,
    output logic                                                  out_last
`ifdef LINEBUF_WEIGHT_LATCH_EN
    ,
    input  logic [POINT_WIDTH*CHANNELS*KERNEL_SIZE*KERNEL_SIZE-1:0] weights,
    output logic [POINT_WIDTH*CHANNELS*KERNEL_SIZE*KERNEL_SIZE-1:0] filter
`endif
);

    localparam int K    = KERNEL_SIZE;
    localparam int PXW  = POINT_WIDTH * CHANNELS;
    localparam int CW   = cnt_w(IMG_WIDTH);
    localparam int RW   = cnt_w(IMG_HEIGHT);
    localparam int SW   = cnt_w(STRIDE);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
    localparam logic [RW-1:0] ROW_K2   = RW'(K - 2);
    localparam logic [SW-1:0] PH_LAST  = SW'(STRIDE - 1);

    lb_state_e                       state_q, state_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [SW-1:0]                   col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic                            out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [K-1:0][K-1:0][PXW-1:0]    win_q, win_d;
    logic [K-2:0][PXW-1:0]           ld_din, tap;
    logic                            accept, last_col, last_row, emit;

    assign in_ready  = (state_q != DRAIN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);

    // tap[0] is the previous row, tap[K-2] the oldest row held
    for (genvar i = 0; i < K - 1; i++) begin : g_ld
        if (i == 0) begin : g_head
            assign ld_din[i] = in_data;
        end else begin : g_chain
            assign ld_din[i] = tap[i-1];
        end
        line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PXW)) u_ld (
            .clock (clock),
            .reset (reset),
            .en    (accept),
            .din   (ld_din[i]),
            .dout  (tap[i])
        );
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign window[(K*K*CHANNELS - CHANNELS - win_idx(r, c, 0, K, CHANNELS))*POINT_WIDTH +: PXW] = win_q[r][c];
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        col_ph_d    = col_ph_q;
        row_ph_d    = row_ph_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        emit        = 1'b0;
        if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (accept) begin
            col_d    = last_col ? '0 : col_q + 1'b1;
            // phases count (pos-(K-1)) mod STRIDE once the window fits
            col_ph_d = (last_col || col_q < COL_K1 || col_ph_q == PH_LAST) ? '0 : col_ph_q + 1'b1;
            if (last_col) begin
                row_d    = last_row ? '0 : row_q + 1'b1;
                row_ph_d = (last_row || row_q < ROW_K1 || row_ph_q == PH_LAST) ? '0 : row_ph_q + 1'b1;
            end
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++)
                    win_d[r][c] = win_q[r][c+1];
            for (int r = 0; r < K - 1; r++)
                win_d[r][K-1] = tap[K-2-r];
            win_d[K-1][K-1] = in_data;
            emit = (row_q >= ROW_K1) && (col_q >= COL_K1) && (row_ph_q == '0) && (col_ph_q == '0);
            if (emit) begin
                out_valid_d = 1'b1;
                out_last_d  = last_col && last_row;
            end
        end
        case (state_q)
            FILL:    if (accept && last_col && row_q == ROW_K2) state_d = RUN;
            RUN:     if (accept && last_col && last_row) state_d = DRAIN;
            DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            col_ph_q    <= '0;
            row_ph_q    <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_ph_q    <= col_ph_d;
            row_ph_q    <= row_ph_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef LINEBUF_WEIGHT_LATCH_EN
    logic [POINT_WIDTH*CHANNELS*K*K-1:0] filter_q, filter_d;

    // sampled on the frame's first pixel so a whole frame sees one coefficient set
    always_comb begin
        filter_d = filter_q;
        if (accept && row_q == '0 && col_q == '0) filter_d = weights;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) filter_q <= '0;
        else        filter_q <= filter_d;
    end

    assign filter = filter_q;
`endif

endmodule

// File: tb/tb_stream_linebuffer.sv
// Randomized bench for stream_linebuffer: K=2, 4x4 frames, stride 1 and stride 2 instances.
module tb_stream_linebuffer;

    localparam int K    = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int PXW  = 8;
    localparam int WINW = PXW * K * K;

    typedef struct packed {
        logic [WINW-1:0] w;
        logic            last;
    } win_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid, out_ready;
    logic [PXW-1:0]  in_data;
    logic            in_ready1, out_valid1, out_last1;
    logic            in_ready2, out_valid2, out_last2;
    logic [WINW-1:0] window1, window2;
`ifdef LINEBUF_WEIGHT_LATCH_EN
    logic [WINW-1:0] weights, filter1, filter2;
`endif

    int   vectors = 0;
    int   errors  = 0;
    win_t got1[$], got2[$], exp_q[$];
    logic [PXW-1:0] pix_q[$];

    always #5 clock = ~clock;

    stream_linebuffer #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .POINT_WIDTH(PXW),
                        .CHANNELS(1), .STRIDE(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .window(window1), .out_last(out_last1)
`ifdef LINEBUF_WEIGHT_LATCH_EN
        , .weights(weights), .filter(filter1)
`endif
    );

    stream_linebuffer #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .POINT_WIDTH(PXW),
                        .CHANNELS(1), .STRIDE(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .window(window2), .out_last(out_last2)
`ifdef LINEBUF_WEIGHT_LATCH_EN
        , .weights(weights), .filter(filter2)
`endif
    );

    always @(negedge clock) begin
        if (reset) begin
            if (out_valid1 && out_ready) got1.push_back(win_t'{w: window1, last: out_last1});
            if (out_valid2 && out_ready) got2.push_back(win_t'{w: window2, last: out_last2});
        end
    end

    // Reference: every window origin on the stride grid, row-major, oldest row first.
    function automatic void model_frame(input logic [PXW-1:0] f [W*H], input int s);
        logic [WINW-1:0] w;
        for (int r0 = 0; r0 <= H - K; r0 += s)
            for (int c0 = 0; c0 <= W - K; c0 += s) begin
                w = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w = (w << PXW) | WINW'(f[(r0 + r) * W + c0 + c]);
                exp_q.push_back(win_t'{w: w, last: (r0 == H - K && c0 == W - K)});
            end
    endfunction

    task automatic add_frame(input logic [PXW-1:0] f [W*H], input int s);
        for (int i = 0; i < W * H; i++) pix_q.push_back(f[i]);
        model_frame(f, s);
    endtask

    task automatic ramp_frame(input int base, input int s);
        logic [PXW-1:0] f [W*H];
        for (int i = 0; i < W * H; i++) f[i] = PXW'(base + i);
        add_frame(f, s);
    endtask

    task automatic rand_frame(input int s);
        logic [PXW-1:0] f [W*H];
        for (int i = 0; i < W * H; i++) f[i] = PXW'($urandom);
        add_frame(f, s);
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        got1.delete(); got2.delete(); exp_q.delete(); pix_q.delete();
    endtask

    // Feeds n pixels from pix_q, gated by dut1's in_ready; returns cycles spent.
    task automatic drive(input int n, input int vpct, input int rpct, output int cycles);
        int  acc_n = 0;
        bit  acc;
        cycles = 0;
        while (acc_n < n && cycles < 2000) begin
            in_valid  = ($urandom_range(99) < vpct);
            in_data   = pix_q[0];
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clock);
            acc = in_valid && in_ready1;
            @(posedge clock); #1;
            cycles++;
            if (acc) begin
                void'(pix_q.pop_front());
                acc_n++;
            end
        end
        in_valid = 1'b0;
        if (acc_n < n) begin
            errors++;
            $display("FAIL drive_timeout accepted %0d required %0d", acc_n, n);
        end
    endtask

    task automatic drain(input int rpct);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i >= 30) || ($urandom_range(99) < rpct);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef LINEBUF_WEIGHT_LATCH_EN
        weights = '0;
`endif
        #3;
        vectors++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid1); end
        vectors++; if (out_last1 !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last1); end
        vectors++; if (window1 !== '0) begin errors++; $display("FAIL reset_window got %h exp 0", window1); end
        vectors++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready1); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        vectors++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++; $display("FAIL post_reset in_ready/out_valid got %b/%b exp 1/0", in_ready1, out_valid1);
        end
    endtask

    task automatic test_ramp();
        int cyc;
        apply_reset();
        ramp_frame(0, 1);
        drive(16, 100, 100, cyc);
        drain(100);
        vectors++; if (got1.size() !== 9) begin errors++; $display("FAIL ramp_count got %0d exp 9", got1.size()); end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            vectors++;
            if (got1[i] !== exp_q[i]) begin
                errors++; $display("FAIL ramp_win%0d got %h/%0b exp %h/%0b", i, got1[i].w, got1[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        vectors++; if (got1.size() < 1 || got1[0].w !== 32'h00010405) begin errors++; $display("FAIL ramp_first mismatched exp 00010405"); end
        vectors++; if (got1.size() < 9 || got1[8] !== win_t'{w: 32'h0a0b0e0f, last: 1'b1}) begin
            errors++; $display("FAIL ramp_last mismatched exp 0a0b0e0f/1");
        end
    endtask

    task automatic test_stride();
        int cyc;
        apply_reset();
        ramp_frame(0, 2);
        drive(16, 100, 100, cyc);
        drain(100);
        vectors++; if (got2.size() !== 4) begin errors++; $display("FAIL stride_count got %0d exp 4", got2.size()); end
        for (int i = 0; i < exp_q.size() && i < got2.size(); i++) begin
            vectors++;
            if (got2[i] !== exp_q[i]) begin
                errors++; $display("FAIL stride_win%0d got %h/%0b exp %h/%0b", i, got2[i].w, got2[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        vectors++; if (got2.size() < 2 || got2[1].w !== 32'h02030607) begin errors++; $display("FAIL stride_second mismatched exp 02030607"); end
    endtask

    task automatic test_stall();
        int a = 0, c = 0, cyc;
        bit acc;
        logic [WINW-1:0] held;
        logic held_last;
        apply_reset();
        ramp_frame(0, 1);
        out_ready = 1'b1; in_valid = 1'b1;
        while (!out_valid1 && c < 100) begin
            in_data = pix_q[0];
            @(negedge clock); acc = in_ready1;
            @(posedge clock); #1;
            c++;
            if (acc) begin void'(pix_q.pop_front()); a++; end
        end
        vectors++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL stall_first_valid got %b exp 1", out_valid1); end
        held = window1; held_last = out_last1;
        vectors++; if (held !== 32'h00010405) begin errors++; $display("FAIL stall_held got %h exp 00010405", held); end
        out_ready = 1'b0; in_data = pix_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %b exp 0", i, in_ready1); end
            vectors++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL stall_out_valid c%0d got %b exp 1", i, out_valid1); end
            vectors++; if (window1 !== held || out_last1 !== held_last) begin
                errors++; $display("FAIL stall_hold c%0d got %h/%b exp %h/%b", i, window1, out_last1, held, held_last);
            end
            @(posedge clock); #1;
        end
        drive(16 - a, 80, 70, cyc);
        drain(70);
        vectors++; if (got1.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got %0d exp %0d", got1.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            vectors++;
            if (got1[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_win%0d got %h/%0b exp %h/%0b", i, got1[i].w, got1[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset();
        rand_frame(1);
        drive(10, 100, 100, cyc);
        reset = 1'b0;
        #1;
        vectors++; if (out_valid1 !== 1'b0 || out_last1 !== 1'b0) begin
            errors++; $display("FAIL midreset_out got %b/%b exp 0/0", out_valid1, out_last1);
        end
        vectors++; if (window1 !== '0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL midreset_state got %h/%b exp 0/1", window1, in_ready1);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        got1.delete(); got2.delete(); exp_q.delete(); pix_q.delete();
        ramp_frame(0, 1);
        drive(16, 100, 100, cyc);
        drain(100);
        vectors++; if (got1.size() !== 9) begin errors++; $display("FAIL midreset_count got %0d exp 9", got1.size()); end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            vectors++;
            if (got1[i] !== exp_q[i]) begin
                errors++; $display("FAIL midreset_win%0d got %h/%0b exp %h/%0b", i, got1[i].w, got1[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        apply_reset();
        ramp_frame(0, 1);
        ramp_frame(100, 1);
        drive(32, 100, 100, cyc);
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL b2b_cycles got %0d exp 33", cyc); end
        drain(100);
        vectors++; if (got1.size() !== 18) begin errors++; $display("FAIL b2b_count got %0d exp 18", got1.size()); end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            vectors++;
            if (got1[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_win%0d got %h/%0b exp %h/%0b", i, got1[i].w, got1[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        vectors++; if (got1.size() < 10 || got1[9].w !== 32'h64656869) begin errors++; $display("FAIL b2b_second_first exp 64656869"); end
    endtask

    task automatic test_random();
        int cyc;
        apply_reset();
        for (int f = 0; f < 3; f++) rand_frame(1);
        drive(48, 70, 60, cyc);
        drain(60);
        vectors++; if (got1.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got1.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            vectors++;
            if (got1[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_win%0d got %h/%0b exp %h/%0b", i, got1[i].w, got1[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
    endtask

`ifdef LINEBUF_WEIGHT_LATCH_EN
    task automatic test_weight_latch();
        int cyc;
        logic [WINW-1:0] wa, wb, wc;
        wa = WINW'($urandom); wb = ~wa; wc = wa ^ 32'h5a5a5a5a;
        apply_reset();
        vectors++; if (filter1 !== '0) begin errors++; $display("FAIL wl_reset got %h exp 0", filter1); end
        weights = wa;
        ramp_frame(0, 1);
        ramp_frame(50, 1);
        drive(1, 100, 100, cyc);
        vectors++; if (filter1 !== wa) begin errors++; $display("FAIL wl_latch got %h exp %h", filter1, wa); end
        weights = wb;
        drive(8, 80, 80, cyc);
        vectors++; if (filter1 !== wa) begin errors++; $display("FAIL wl_midframe got %h exp %h", filter1, wa); end
        drive(7, 80, 80, cyc);
        vectors++; if (filter1 !== wa) begin errors++; $display("FAIL wl_endframe got %h exp %h", filter1, wa); end
        weights = wc;
        drive(1, 100, 100, cyc);
        vectors++; if (filter1 !== wc) begin errors++; $display("FAIL wl_nextframe got %h exp %h", filter1, wc); end
        drive(15, 100, 100, cyc);
        drain(100);
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_stride();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef LINEBUF_WEIGHT_LATCH_EN
        test_weight_latch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
